// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping detection, prefix-progress readout and a saturating match counter.
module seq_detector_param #(
  parameter int                PAT_W   = 4,
  parameter int                CNT_W   = 8,
  parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(4'b1011)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data,
  input  logic                       valid,
  input  logic                       overlap,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic                       cnt_clr,
  output logic [$clog2(PAT_W)-1:0]   state_out,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int SO_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_now;
  logic [SO_W-1:0]   state_d;
  logic [PAT_W-1:0]  diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_RST;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], data};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    match_now  = valid & ~cfg_load & (fill_inc == FILL_FULL) & (hist_shift == pat_q);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = match_now;
    cnt_d  = cnt_q;

    // cfg_load wins over valid: the data bit on a load edge is dropped.
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      fill_d = '0;
    end else if (valid) begin
      hist_d = hist_shift;
      fill_d = (match_now && !overlap) ? '0 : fill_inc;
    end

    if (cnt_clr) begin
      cnt_d = {{(CNT_W-1){1'b0}}, match_now};
    end else if (match_now && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Longest pattern prefix that ends the accepted history; ascending scan keeps the largest.
  always_comb begin
    state_d = '0;
    diff    = '0;
    for (int k = 1; k < PAT_W; k++) begin
      diff = (hist_q ^ (pat_q >> (PAT_W - k))) & ({PAT_W{1'b1}} >> (PAT_W - k));
      if ((k <= int'(fill_q)) && (diff == '0)) begin
        state_d = SO_W'(k);
      end
    end
  end

  assign state_out = state_d;
  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, hand-built corner sequences and
// random traffic against a bit-queue reference model.
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic       valid;
  logic       overlap;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cnt_clr;
  logic [1:0] state_out, state2;
  logic       out, out2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_param u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .state_out(state_out), .out(out), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1111)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .state_out(state2), .out(out2), .match_cnt(cnt2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: the accepted bits since the last discard, newest last
  logic       q[$];
  logic [3:0] m_pat;
  logic       m_out;
  int         m_cnt;

  function automatic void model_reset();
    q.delete();
    m_pat = 4'b1011;
    m_out = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic bool_match();
    return 1'b0;
  endfunction

  function automatic int m_state();
    int best = 0;
    int n = q.size();
    for (int k = 1; k <= 3; k++) begin
      if (k <= n) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (q[n-k+j] != m_pat[3-j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic void model_step();
    bit hit = 1'b0;
    m_out = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      q.delete();
    end else if (valid) begin
      q.push_back(data);
      if (q.size() > 4) void'(q.pop_front());
      if (q.size() == 4) begin
        hit = 1'b1;
        for (int i = 0; i < 4; i++)
          if (q[i] != m_pat[3-i]) hit = 1'b0;
      end
      m_out = hit;
      if (hit && !overlap) q.delete();
    end
    if (cnt_clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " out"}, int'(out), int'(m_out));
    chk({tag, " state_out"}, int'(state_out), m_state());
    chk({tag, " match_cnt"}, int'(match_cnt), m_cnt);
  endtask

  // drivers
  task automatic tick(input logic d, input logic v, input logic ov,
                      input logic ld, input logic [3:0] cp, input logic clr);
    @(negedge clk);
    data = d; valid = v; overlap = ov; cfg_load = ld; cfg_pattern = cp; cnt_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    model_check("model");
  endtask

  task automatic bit_in(input logic d, input logic ov);
    tick(d, 1'b1, ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #1;
    chk("reset state_out", int'(state_out), 0);
    chk("reset out", int'(out), 0);
    chk("reset match_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic ov;
    logic e_out;
    int   e_state;
    int   e_cnt;
  } vec_t;

  vec_t tbl[14];
  logic [6:0] stream;

  initial begin
    rst_n = 1'b0; data = 1'b0; valid = 1'b0; overlap = 1'b0;
    cfg_load = 1'b0; cfg_pattern = 4'b0000; cnt_clr = 1'b0;
    model_reset();

    // 1011 overlapping then non-overlapping over the stream 1,0,1,1,0,1,1
    stream = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      tbl[i].rst   = (i == 0);
      tbl[i].d     = stream[6-i];
      tbl[i].ov    = 1'b1;
      tbl[i+7].rst = (i == 0);
      tbl[i+7].d   = stream[6-i];
      tbl[i+7].ov  = 1'b0;
    end
    tbl[0].e_out = 0; tbl[0].e_state = 1; tbl[0].e_cnt = 0;
    tbl[1].e_out = 0; tbl[1].e_state = 2; tbl[1].e_cnt = 0;
    tbl[2].e_out = 0; tbl[2].e_state = 3; tbl[2].e_cnt = 0;
    tbl[3].e_out = 1; tbl[3].e_state = 1; tbl[3].e_cnt = 1;
    tbl[4].e_out = 0; tbl[4].e_state = 2; tbl[4].e_cnt = 1;
    tbl[5].e_out = 0; tbl[5].e_state = 3; tbl[5].e_cnt = 1;
    tbl[6].e_out = 1; tbl[6].e_state = 1; tbl[6].e_cnt = 2;
    tbl[7].e_out = 0; tbl[7].e_state = 1; tbl[7].e_cnt = 0;
    tbl[8].e_out = 0; tbl[8].e_state = 2; tbl[8].e_cnt = 0;
    tbl[9].e_out = 0; tbl[9].e_state = 3; tbl[9].e_cnt = 0;
    tbl[10].e_out = 1; tbl[10].e_state = 0; tbl[10].e_cnt = 1;
    tbl[11].e_out = 0; tbl[11].e_state = 0; tbl[11].e_cnt = 1;
    tbl[12].e_out = 0; tbl[12].e_state = 1; tbl[12].e_cnt = 1;
    tbl[13].e_out = 0; tbl[13].e_state = 1; tbl[13].e_cnt = 1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      bit_in(tbl[i].d, tbl[i].ov);
      chk($sformatf("tbl[%0d] out", i), int'(out), int'(tbl[i].e_out));
      chk($sformatf("tbl[%0d] state_out", i), int'(state_out), tbl[i].e_state);
      chk($sformatf("tbl[%0d] match_cnt", i), int'(match_cnt), tbl[i].e_cnt);
    end

    // valid gap with data toggling holds progress
    do_reset();
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(logic'(i % 2), 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("gap state_out", int'(state_out), 3);
      chk("gap out", int'(out), 0);
    end
    bit_in(1, 1);
    chk("gap match out", int'(out), 1);
    chk("gap match_cnt", int'(match_cnt), 1);

    // asynchronous reset in the middle of a pattern
    do_reset();
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    #2;
    rst_n = 1'b0; valid = 1'b0; cnt_clr = 1'b0; cfg_load = 1'b0;
    model_reset();
    #1;
    chk("async state_out", int'(state_out), 0);
    chk("async match_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bit_in(1, 1);
    chk("post-reset out", int'(out), 0);
    chk("post-reset state_out", int'(state_out), 1);

    // pattern reload mid-stream
    do_reset();
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    chk("load state_out", int'(state_out), 0);
    chk("load out", int'(out), 0);
    bit_in(0, 0); bit_in(1, 0); bit_in(1, 0); bit_in(0, 0);
    chk("new pattern out", int'(out), 1);
    bit_in(1, 0); chk("old pattern out0", int'(out), 0);
    bit_in(0, 0); chk("old pattern out1", int'(out), 0);
    bit_in(1, 0); chk("old pattern out2", int'(out), 0);
    bit_in(1, 0); chk("old pattern out3", int'(out), 0);
    chk("reload match_cnt", int'(match_cnt), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    chk("clear no match", int'(match_cnt), 0);

    // 2-bit counter saturation on 1111, then clear with a coincident match
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bit_in(1, 1);
      chk($sformatf("sat out bit%0d", i + 1), int'(out2), (i >= 3) ? 1 : 0);
      chk($sformatf("sat cnt bit%0d", i + 1), int'(cnt2), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("clr with match", int'(cnt2), 1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("clr without match", int'(cnt2), 0);

    // random traffic against the model
    do_reset();
    begin
      logic ov_r = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 39) == 0) ov_r = ~ov_r;
        tick(logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 3) != 0),
             ov_r,
             logic'($urandom_range(0, 24) == 0),
             4'($urandom_range(0, 15)),
             logic'($urandom_range(0, 29) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
